// File: rtl/mips_arith_pkg.sv
// Shared arithmetic definitions for the MIPS64 execute-stage iterative units
// (sequential multiplier and sequential divider).
//   state_t : control states shared by the iterative units
//   WIDTH   : native operand width
//   ITERS   : iterations per operation (one result bit per clock)
//   CTR_W   : iteration counter width, 2**CTR_W > ITERS
package mips_arith_pkg;

    localparam int unsigned WIDTH     = 64;
    localparam int unsigned ITERS     = 64;
    localparam int unsigned CTR_W     = 7;

    // Divider-side constants live here too so both units stay in step.
    localparam int unsigned DIV_ITERS = ITERS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add multiplier iteration on the {carry, acc} pair.
//   acc        : current accumulator, {partial product high half, remaining multiplier bits}
//   ma         : multiplicand magnitude
//   acc_next_c : accumulator after conditional add of ma and a 1-bit right shift
module mult_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   ma,
    output logic [2*WIDTH-1:0] acc_next_c
);

    logic [WIDTH:0] sum_c;

    // The add is WIDTH+1 bits wide so the carry survives into the shift.
    always_comb begin
        sum_c = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum_c = sum_c + {1'b0, ma};
        end
        acc_next_c = {sum_c, acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier producing a 2*WIDTH product as hi/lo halves.
// Signed operands are converted to magnitudes at launch; the product is
// negated once at the end when the operand signs differ.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : launch request, sampled only while idle
//   is_signed  : 1 = two's-complement operands, 0 = unsigned
//   a, b       : operands, captured with start
//   busy       : operation in flight (cycle after accept through done)
//   done       : one-cycle pulse, hi/lo valid in the same cycle
//   hi, lo     : upper/lower halves of the last product
module multiplier_seq #(
    parameter int unsigned WIDTH = mips_arith_pkg::WIDTH,
    parameter int unsigned CTR_W = mips_arith_pkg::CTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mips_arith_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [PW-1:0]    step_acc_c;
    logic [PW-1:0]    product_c;

    // Magnitudes; the most negative value maps to 2**(WIDTH-1), valid unsigned.
    always_comb begin
        mag_a_c = a;
        mag_b_c = b;
        if (is_signed && a[WIDTH-1]) begin
            mag_a_c = ~a + WIDTH'(1);
        end
        if (is_signed && b[WIDTH-1]) begin
            mag_b_c = ~b + WIDTH'(1);
        end
    end

    mult_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .acc        (acc_q),
        .ma         (ma_q),
        .acc_next_c (step_acc_c)
    );

    // Final sign fix; negating zero stays zero.
    always_comb begin
        product_c = acc_q;
        if (neg_q) begin
            product_c = ~acc_q + PW'(1);
        end
    end

    // Next state, datapath next values and registered-output next values.
    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        ctr_d   = ctr_q;
        hi_d    = hi;
        lo_d    = lo;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d    = mag_a_c;
                    acc_d   = {{WIDTH{1'b0}}, mag_b_c};
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    ctr_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc_c;
                ctr_d = ctr_q + CTR_W'(1);
                if (ctr_q == CTR_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = product_c[PW-1:WIDTH];
                lo_d    = product_c[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ma_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            ctr_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            ctr_q   <= ctr_d;
            busy    <= busy_d;
            done    <= done_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: directed vector table, randomized
// operands against an arithmetic reference, and handshake/reset sequences.
module tb_multiplier_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] hi;
    logic [63:0] lo;

    int passed;
    int total;

    multiplier_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] hi;
        logic [63:0] lo;
    } vec_t;

    vec_t tbl [10];

    // Product of the operands as integers, reduced mod 2**128.
    function automatic logic [127:0] ref_mul(input bit s, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] ex;
        logic [127:0] ey;
        ex = s ? {{64{x[63]}}, x} : {64'd0, x};
        ey = s ? {{64{y[63]}}, y} : {64'd0, y};
        return ex * ey;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Launch one operation, scramble inputs after capture, verify timing and result.
    task automatic do_mult(input bit s, input logic [63:0] av, input logic [63:0] bv,
                           input logic [127:0] exp, input string nm);
        int n;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1; is_signed = s; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        is_signed = 1'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({nm, " latency"}, 128'(n), 128'd65);
        check({nm, " busy"}, 128'(busy_ok), 128'd1);
        check({nm, " product"}, {hi, lo}, exp);
        check({nm, " busy@done"}, 128'(busy), 128'd1);
        @(posedge clk); #1;
        check({nm, " done drop"}, 128'({busy, done}), 128'd0);
    endtask

    initial begin
        int n;
        int ndone;
        int first;
        int second;
        int bsy;
        bit s;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] specials [4];

        passed = 0;
        total  = 0;

        tbl[0] = '{1'b0, 64'd3, 64'd5, 64'd0, 64'd15};
        tbl[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1};
        tbl[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
        tbl[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0};
        tbl[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        tbl[5] = '{1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0};
        tbl[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
        tbl[7] = '{1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0};
        tbl[8] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0};
        tbl[9] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};

        specials[0] = 64'h8000_0000_0000_0000;
        specials[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        specials[2] = 64'h0;
        specials[3] = 64'h7FFF_FFFF_FFFF_FFFF;

        // Reset state
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        #1;
        check("reset outputs", {62'd0, busy, done, hi}, 128'd0);
        check("reset lo", 128'(lo), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_mult(tbl[i].s, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, $sformatf("vec%0d", i));
        end

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 16; i++) begin
            s  = 1'($urandom);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 3)];
            do_mult(s, ra, rb, ref_mul(s, ra, rb), $sformatf("rnd%0d", i));
        end

        // Second start while busy is ignored; start in DONE is not accepted
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 64'd7; b = 64'd6;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (n = 1; n <= 200 && first < 0; n++) begin
            if (n == 10) begin start = 1'b1; a = 64'd2; b = 64'd2; end
            if (n == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin ndone++; first = n; end
        end
        check("hs latency", 128'(first), 128'd65);
        check("hs product", {hi, lo}, 128'd42);
        start = 1'b1; a = 64'd2; b = 64'd2;
        @(posedge clk); #1;
        check("hs idle after done", 128'({busy, done}), 128'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("hs reaccept busy", 128'(busy), 128'd1);
        first = -1;
        for (n = 1; n <= 200 && first < 0; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin ndone++; first = n; end
        end
        check("hs2 latency", 128'(first), 128'd65);
        check("hs2 product", {hi, lo}, 128'd4);
        check("hs done count", 128'(ndone), 128'd2);
        @(posedge clk); #1;

        // Reset mid-operation aborts without a done
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 64'd9; b = 64'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy/done", 128'({busy, done}), 128'd0);
        check("abort hi/lo", {hi, lo}, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        bsy = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) bsy++;
        end
        check("abort no done", 128'(ndone), 128'd0);
        check("abort stays idle", 128'(bsy), 128'd0);
        do_mult(1'b0, 64'd9, 64'd9, 128'd81, "post-reset");

        // Start held high: one product every 67 cycles
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 64'd11; b = 64'd13;
        first = -1;
        second = -1;
        for (n = 1; n <= 300 && second < 0; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        start = 1'b0;
        check("held spacing", 128'(second - first), 128'd67);
        check("held product", {hi, lo}, 128'd143);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("held drains", 128'(busy), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multiplier_seq.md
Name: multiplier_seq

Overview:
- Iterative 64x64 shift-add multiplier, the inverse-direction companion to the sequential divider in the MIPS64 execute stage.
- Produces a 128-bit product split into HI/LO halves for MULT/MULTU (DMULT/DMULTU).
- Operands are launched with a start/busy/done handshake.
- One product bit is resolved per clock. Signed operation works on magnitudes, then fixes the sign.

Parameters:
- WIDTH, 64, operand width; product is 2*WIDTH.
- CTR_W, 7, iteration counter width; must satisfy 2^CTR_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU); captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high from the cycle after accept until done deasserts.
- done  output  1  one-cycle pulse; hi/lo valid in the same cycle.
- hi  output  WIDTH  product[2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal registers=0. Reset mid-operation aborts it, and no done is produced.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - On the edge where start=1, capture operands:
    - ma = is_signed & a[63] ? -a : a; mb likewise from b.
    - neg = is_signed & (a[63] ^ b[63]).
    - acc = {64'b0, mb}; counter = 0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, one iteration per edge:
  - If acc[0]=1, add ma to acc[127:64] with a 65-bit carry.
  - Shift {carry, acc} right by 1.
  - counter++. After the 64th iteration (counter reaches 64), go to FIX.
- FIX: product = neg ? -acc : acc (128-bit two's complement). Load hi/lo; go to DONE.
- DONE: done=1 for exactly this cycle; busy=1. Next edge goes to IDLE with busy=0 and done=0.
- Latency: start accepted at edge 0; RUN at edges 1..64; FIX at edge 65; done high in the cycle after edge 65; the block accepts start again at edge 67.
- hi/lo hold the last product until the next FIX or reset. They are never updated during RUN.
- start while busy (RUN/FIX/DONE) is ignored. Operand changes after capture have no effect.
- Width rules:
  - Negating the most negative value (0x8000_0000_0000_0000) yields magnitude 2^63, which is correct as an unsigned 64-bit value.
  - The accumulator add must keep the carry bit, so no overflow is lost.
  - Unsigned mode never negates.
- Zero operand: still takes the full 64 iterations; result 0. neg may be 1, but -0 = 0.
- Continuous start held high: one product per 67 cycles, with no double-accept in DONE.

Decomposition:
- Shared package mips_arith_pkg:
  - state enum {IDLE, RUN, FIX, DONE}
  - constants WIDTH=64, ITERS=64
  - the same package also serves the divider's constants
- One natural sub-module, mult_step: combinational conditional add plus 1-bit shift of the 129-bit {carry, acc}. The FSM/counter stays in the top level.

Test Plan:
- Unsigned basic: is_signed=0, a=3, b=5 -> done at cycle 66 after accept; hi=0, lo=15; busy high cycles 1..66.
- Signed negative: is_signed=1, a=-3 (0xFFFF_FFFF_FFFF_FFFD), b=5 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFF1.
- Unsigned carry: is_signed=0, a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0001.
- Signed extremes: is_signed=1, a=b=0x8000_0000_0000_0000 -> hi=0x4000_0000_0000_0000, lo=0.
- Handshake: pulse start with a=7, b=6; at cycle 10 pulse start with a=2, b=2 -> second start ignored; result 42; exactly one done pulse. A new start at the first IDLE cycle gives 4.
- Reset mid-op: start a=9, b=9; drop rst_n at cycle 30 for 2 cycles -> hi=lo=0, busy=0, no done; the next start a=9, b=9 gives 81.
